tcam_pipe: RTL and testbench

- Parametrised, clocked ternary CAM: DEPTH entries of WIDTH bits, each with a per-bit don't-care mask and a valid bit.
- Supports one search per clock through a 2-stage pipeline. Returns a registered match vector, lowest-index hit, hit count and multi-hit flag.
- Successor to the 16x16 combinational match-line block. Sits in the lookup datapath in front of the address decoder.

---
 rtl/tcam_pipe.sv | 127 ++++++++++++
 tb/tb_tcam_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tcam_pipe.sv
// Ternary CAM with a per-entry don't-care mask and a valid bit.
// Two-stage search pipeline: stage 1 registers the match lines, stage 2 registers the encoded results.
module tcam_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned IDX_W = $clog2(DEPTH),
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [WIDTH-1:0] wr_mask,
   input  logic             wr_valid,
   input  logic             flush,
   input  logic             srch_en,
   input  logic [WIDTH-1:0] srch_key,
   output logic             res_valid,
   output logic [DEPTH-1:0] match_vec,
   output logic             hit,
   output logic [IDX_W-1:0] hit_idx,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             multi_hit
);

   logic [WIDTH-1:0] r_data [DEPTH];
   logic [WIDTH-1:0] r_mask [DEPTH];
   logic [DEPTH-1:0] r_valid;

   logic             r_s1_vld;
   logic [DEPTH-1:0] r_s1_vec;

   logic             r_res_valid;
   logic [DEPTH-1:0] r_match_vec;
   logic             r_hit;
   logic [IDX_W-1:0] r_hit_idx;
   logic [CNT_W-1:0] r_hit_cnt;
   logic             r_multi_hit;

   logic [DEPTH-1:0] w_match;
   logic [IDX_W-1:0] w_idx;
   logic [CNT_W-1:0] w_cnt;

   // Entry payload has no reset; only the valid bits carry state that matters after reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_data[wr_addr] <= wr_data;
         r_mask[wr_addr] <= wr_mask;
      end
   end

   // Flush is applied after the write so it overrides a same-cycle valid write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else begin
         if (wr_en) begin
            r_valid[wr_addr] <= wr_valid;
         end
         if (flush) begin
            r_valid <= '0;
         end
      end
   end

   always_comb begin
      w_match = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_match[i] = r_valid[i] && (((r_data[i] ^ srch_key) & ~r_mask[i]) == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s1_vec <= '0;
      end else begin
         r_s1_vld <= srch_en;
         if (srch_en) begin
            r_s1_vec <= w_match;
         end
      end
   end

   // Downward scan so the lowest set index is the last assignment.
   always_comb begin
      w_idx = '0;
      w_cnt = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (r_s1_vec[i]) begin
            w_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_cnt = w_cnt + CNT_W'(r_s1_vec[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_res_valid <= 1'b0;
         r_match_vec <= '0;
         r_hit       <= 1'b0;
         r_hit_idx   <= '0;
         r_hit_cnt   <= '0;
         r_multi_hit <= 1'b0;
      end else begin
         r_res_valid <= r_s1_vld;
         if (r_s1_vld) begin
            r_match_vec <= r_s1_vec;
            r_hit       <= |r_s1_vec;
            r_hit_idx   <= w_idx;
            r_hit_cnt   <= w_cnt;
            r_multi_hit <= w_cnt > CNT_W'(1);
         end
      end
   end

   assign res_valid = r_res_valid;
   assign match_vec = r_match_vec;
   assign hit       = r_hit;
   assign hit_idx   = r_hit_idx;
   assign hit_cnt   = r_hit_cnt;
   assign multi_hit = r_multi_hit;

endmodule

// File: tb/tb_tcam_pipe.sv
// Directed bench for tcam_pipe: hand-computed expectations checked with immediate assertions.
module tb_tcam_pipe;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 5;

   logic             clk;
   logic             rst;
   logic             wr_en;
   logic [IDX_W-1:0] wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] wr_mask;
   logic             wr_valid;
   logic             flush;
   logic             srch_en;
   logic [WIDTH-1:0] srch_key;
   logic             res_valid;
   logic [DEPTH-1:0] match_vec;
   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   logic [CNT_W-1:0] hit_cnt;
   logic             multi_hit;

   int total = 0;
   int bad   = 0;

   tcam_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_valid(wr_valid),
      .flush(flush), .srch_en(srch_en), .srch_key(srch_key),
      .res_valid(res_valid), .match_vec(match_vec), .hit(hit), .hit_idx(hit_idx),
      .hit_cnt(hit_cnt), .multi_hit(multi_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [IDX_W-1:0] a, input logic [WIDTH-1:0] d,
                     input logic [WIDTH-1:0] m, input logic v);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m; wr_valid = v;
      step();
      wr_en = 1'b0;
   endtask

   task automatic srch(input logic [WIDTH-1:0] k);
      srch_en = 1'b1; srch_key = k;
      step();
      srch_en = 1'b0;
   endtask

   logic [WIDTH-1:0] b2b_key [4];
   logic             b2b_hit [4];
   logic [IDX_W-1:0] b2b_idx [4];

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0; wr_valid = 1'b0;
      flush = 1'b0; srch_en = 1'b0; srch_key = '0;
      step(); step();
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_match_vec", 32'(match_vec), 32'd0);
      chk("rst_hit",       32'(hit),       32'd0);
      chk("rst_hit_idx",   32'(hit_idx),   32'd0);
      chk("rst_hit_cnt",   32'(hit_cnt),   32'd0);
      chk("rst_multi",     32'(multi_hit), 32'd0);
      rst = 1'b0;

      // Empty table search, two-cycle latency
      srch(16'h0000);
      chk("lat_s1_no_valid", 32'(res_valid), 32'd0);
      step();
      chk("empty_res_valid", 32'(res_valid), 32'd1);
      chk("empty_hit",       32'(hit),       32'd0);
      chk("empty_vec",       32'(match_vec), 32'd0);
      chk("empty_cnt",       32'(hit_cnt),   32'd0);
      chk("empty_idx",       32'(hit_idx),   32'd0);

      // Ternary match on low nibble
      wr(4'd3, 16'h12F0, 16'h000F, 1'b1);
      srch(16'h12F7);
      srch(16'h13F7);
      chk("tern_hit",   32'(hit),       32'd1);
      chk("tern_idx",   32'(hit_idx),   32'd3);
      chk("tern_vec",   32'(match_vec), 32'h0008);
      chk("tern_cnt",   32'(hit_cnt),   32'd1);
      step();
      chk("tern_miss_valid", 32'(res_valid), 32'd1);
      chk("tern_miss_hit",   32'(hit),       32'd0);
      chk("tern_miss_vec",   32'(match_vec), 32'd0);

      // Priority and multi-hit, including an all-don't-care entry
      wr(4'd5,  16'hABCD, 16'h0000, 1'b1);
      wr(4'd9,  16'hABCD, 16'h0000, 1'b1);
      wr(4'd12, 16'h0000, 16'hFFFF, 1'b1);
      srch(16'hABCD);
      step();
      chk("multi_idx",   32'(hit_idx),   32'd5);
      chk("multi_cnt",   32'(hit_cnt),   32'd3);
      chk("multi_flag",  32'(multi_hit), 32'd1);
      chk("multi_vec",   32'(match_vec), 32'h1220);
      step();
      chk("hold_valid",  32'(res_valid), 32'd0);
      chk("hold_idx",    32'(hit_idx),   32'd5);
      chk("hold_cnt",    32'(hit_cnt),   32'd3);

      // Invalidate entry 12
      wr(4'd12, 16'h0000, 16'hFFFF, 1'b0);
      srch(16'hABCD);
      step();
      chk("inval_vec",   32'(match_vec), 32'h0220);
      chk("inval_cnt",   32'(hit_cnt),   32'd2);

      // Same-cycle write and search hit the old contents
      wr(4'd2, 16'h1111, 16'h0000, 1'b1);
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h2222; wr_mask = 16'h0000; wr_valid = 1'b1;
      srch_en = 1'b1; srch_key = 16'h2222;
      step();
      wr_en = 1'b0;
      srch(16'h2222);
      chk("coll_old_hit", 32'(hit), 32'd0);
      step();
      chk("coll_new_hit", 32'(hit),       32'd1);
      chk("coll_new_idx", 32'(hit_idx),   32'd2);
      chk("coll_new_vec", 32'(match_vec), 32'h0004);

      // Back-to-back searches
      wr(4'd1, 16'h0101, 16'h0000, 1'b1);
      wr(4'd7, 16'h0707, 16'h0000, 1'b1);
      b2b_key[0] = 16'h0101; b2b_hit[0] = 1'b1; b2b_idx[0] = 4'd1;
      b2b_key[1] = 16'h5555; b2b_hit[1] = 1'b0; b2b_idx[1] = 4'd0;
      b2b_key[2] = 16'h0707; b2b_hit[2] = 1'b1; b2b_idx[2] = 4'd7;
      b2b_key[3] = 16'h0101; b2b_hit[3] = 1'b1; b2b_idx[3] = 4'd1;
      for (int k = 0; k < 5; k++) begin
         srch_en  = (k < 4);
         srch_key = (k < 4) ? b2b_key[k] : 16'h0000;
         step();
         if (k >= 1) begin
            chk($sformatf("b2b%0d_valid", k - 1), 32'(res_valid), 32'd1);
            chk($sformatf("b2b%0d_hit",   k - 1), 32'(hit),       32'(b2b_hit[k-1]));
            chk($sformatf("b2b%0d_idx",   k - 1), 32'(hit_idx),   32'(b2b_idx[k-1]));
         end
      end
      srch_en = 1'b0;
      step();
      chk("b2b_end_valid", 32'(res_valid), 32'd0);

      // Flush behind an in-flight search
      srch(16'h0101);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_inflight_hit", 32'(hit),     32'd1);
      chk("flush_inflight_idx", 32'(hit_idx), 32'd1);
      srch(16'h0101);
      step();
      chk("flush_after_valid", 32'(res_valid), 32'd1);
      chk("flush_after_hit",   32'(hit),       32'd0);
      chk("flush_after_cnt",   32'(hit_cnt),   32'd0);

      // Flush wins over a same-cycle valid write
      flush = 1'b1;
      wr(4'd4, 16'h4444, 16'h0000, 1'b1);
      flush = 1'b0;
      srch(16'h4444);
      step();
      chk("flush_wr_hit", 32'(hit), 32'd0);
      wr(4'd4, 16'h4444, 16'h0000, 1'b1);
      srch(16'h4444);
      step();
      chk("rewr_idx", 32'(hit_idx), 32'd4);

      // Reset one cycle after a search discards it
      wr(4'd6, 16'h6666, 16'h0000, 1'b1);
      srch(16'h6666);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_valid", 32'(res_valid), 32'd0);
      chk("rst_mid_hit",   32'(hit),       32'd0);
      chk("rst_mid_vec",   32'(match_vec), 32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("rst_quiet%0d", c), 32'(res_valid), 32'd0);
      end
      srch(16'h6666);
      step();
      chk("rst_cleared_hit", 32'(hit), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
